fix_rx_msg_fifo: RTL and testbench

- Receive-side FIFO controller between the TOE byte stream and the FIX engine's `message_i`/`valid_i`/`new_message_i` inputs.
- Buffers incoming bytes and frames FIX messages by detecting the `<SOH>10=` trailer followed by the closing SOH (0x01).
- Releases only complete messages to the engine, one byte per cycle, with a start-of-message pulse.
- A message that overflows the FIFO is discarded whole.

---
 rtl/fix_rx_msg_fifo.sv | 191 +++++++++++++++++++
 tb/tb_fix_rx_msg_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_rx_msg_fifo.sv
// Receive FIFO that frames FIX messages on the <SOH>10=...<SOH> trailer and releases only complete ones.
// Optional per-message length limit: define FIX_RX_MAX_LEN_EN.
module fix_rx_msg_fifo #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int CNT_W   = 4,
   parameter int MAX_LEN = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic             stall_i,
   output logic [7:0]       message_o,
   output logic             valid_o,
   output logic             new_message_o,
   output logic             end_message_o,
   output logic [CNT_W-1:0] msg_count_o,
   output logic             overflow_o
);
   localparam logic [7:0]       SOH     = 8'h01;
   localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]  DEPTH_P = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {W_BODY, W_S, W_1, W_10, W_CHK} trl_t;
   typedef enum logic [1:0] {R_IDLE, R_START, R_STREAM} rd_state_t;

   // Trailer tracker shared by the write and read sides; W_CHK + SOH closes a message.
   function automatic trl_t trl_next(input trl_t s, input logic [7:0] b);
      trl_t n;
      n = W_BODY;
      if (b == SOH) begin
         n = (s == W_CHK) ? W_BODY : W_S;
      end else begin
         case (s)
            W_S:     n = (b == 8'h31) ? W_1 : W_BODY;
            W_1:     n = (b == 8'h30) ? W_10 : W_BODY;
            W_10:    n = (b == 8'h3D) ? W_CHK : W_BODY;
            W_CHK:   n = W_CHK;
            default: n = W_BODY;
         endcase
      end
      return n;
   endfunction

   logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
   logic [ADDR_W:0]   commit_ptr_reg, commit_ptr_next;
   logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
   trl_t              w_state_reg, w_state_next;
   trl_t              r_trl_reg, r_trl_next;
   rd_state_t         r_state_reg, r_state_next;
   logic              drop_reg, drop_next;
   logic              ovf_reg, ovf_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [7:0]        rd_data_reg;
   logic [7:0]        mem [DEPTH];
   logic              full, msg_done, too_long, wr_en, commit, rd_en, rd_end;
   logic [ADDR_W-1:0] rd_addr;

   assign full     = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;
   assign msg_done = valid_i && (w_state_reg == W_CHK) && (data_i == SOH);

`ifdef FIX_RX_MAX_LEN_EN
   localparam logic [ADDR_W:0] MAX_LEN_P = (ADDR_W+1)'(MAX_LEN);
   assign too_long = !msg_done && ((wr_ptr_reg + PTR_ONE - commit_ptr_reg) == MAX_LEN_P);
`else
   // Keeps MAX_LEN referenced when the length limit is compiled out.
   logic unused_max_len;
   assign unused_max_len = (MAX_LEN != 0);
   assign too_long       = 1'b0;
`endif

   // Write side: store, commit on the closing SOH, or roll back to the last commit.
   always_comb begin
      wr_ptr_next     = wr_ptr_reg;
      commit_ptr_next = commit_ptr_reg;
      w_state_next    = w_state_reg;
      drop_next       = drop_reg;
      ovf_next        = ovf_reg;
      wr_en           = 1'b0;
      commit          = 1'b0;
      if (valid_i) begin
         w_state_next = trl_next(w_state_reg, data_i);
         if (drop_reg) begin
            if (msg_done) drop_next = 1'b0;
         end else if (full || too_long || (msg_done && cnt_reg == CNT_MAX)) begin
            wr_ptr_next = commit_ptr_reg;
            ovf_next    = 1'b1;
            drop_next   = !msg_done;
         end else begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (msg_done) begin
               commit          = 1'b1;
               commit_ptr_next = wr_ptr_reg + PTR_ONE;
            end
         end
      end
   end

   // Read side: one start cycle primes the RAM output, then stream until the closing SOH.
   always_comb begin
      r_state_next  = r_state_reg;
      r_trl_next    = r_trl_reg;
      rd_ptr_next   = rd_ptr_reg;
      new_message_o = 1'b0;
      valid_o       = 1'b0;
      end_message_o = 1'b0;
      rd_en         = 1'b0;
      rd_end        = 1'b0;
      rd_addr       = rd_ptr_reg[ADDR_W-1:0];
      case (r_state_reg)
         R_IDLE: begin
            if (cnt_reg != '0 && !stall_i) r_state_next = R_START;
         end
         R_START: begin
            new_message_o = 1'b1;
            rd_en         = 1'b1;
            r_trl_next    = W_BODY;
            r_state_next  = R_STREAM;
         end
         R_STREAM: begin
            if (!stall_i) begin
               valid_o     = 1'b1;
               rd_ptr_next = rd_ptr_reg + PTR_ONE;
               rd_en       = 1'b1;
               rd_addr     = ADDR_W'(rd_ptr_reg + PTR_ONE);
               r_trl_next  = trl_next(r_trl_reg, rd_data_reg);
               if (r_trl_reg == W_CHK && rd_data_reg == SOH) begin
                  end_message_o = 1'b1;
                  rd_end        = 1'b1;
                  r_state_next  = R_IDLE;
               end
            end
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   always_comb begin
      case ({commit, rd_end})
         2'b10:   cnt_next = cnt_reg + CNT_ONE;
         2'b01:   cnt_next = cnt_reg - CNT_ONE;
         default: cnt_next = cnt_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg[ADDR_W-1:0]] <= data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg     <= '0;
         commit_ptr_reg <= '0;
         rd_ptr_reg     <= '0;
         w_state_reg    <= W_BODY;
         r_trl_reg      <= W_BODY;
         r_state_reg    <= R_IDLE;
         drop_reg       <= 1'b0;
         ovf_reg        <= 1'b0;
         cnt_reg        <= '0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         commit_ptr_reg <= commit_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         w_state_reg    <= w_state_next;
         r_trl_reg      <= r_trl_next;
         r_state_reg    <= r_state_next;
         drop_reg       <= drop_next;
         ovf_reg        <= ovf_next;
         cnt_reg        <= cnt_next;
      end
   end

   assign ready_o     = !full;
   assign message_o   = rd_data_reg;
   assign msg_count_o = cnt_reg;
   assign overflow_o  = ovf_reg;
endmodule

// File: tb/tb_fix_rx_msg_fifo.sv
// Bench for fix_rx_msg_fifo: directed FIX messages ('|' stands for SOH) checked against a
// message-level queue model every cycle, plus hand-computed latency/boundary expectations.
module tb_fix_rx_msg_fifo;
   localparam int DEPTH   = 32;
   localparam int ADDR_W  = 5;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;
   localparam int SOH     = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       data_i = '0;
   logic             valid_i = 1'b0;
   logic             stall_i = 1'b0;
   logic             ready_o, valid_o, new_message_o, end_message_o, overflow_o;
   logic [7:0]       message_o;
   logic [CNT_W-1:0] msg_count_o;

   always #5 clk = ~clk;

   fix_rx_msg_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_LEN(128)) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .stall_i(stall_i), .message_o(message_o), .valid_o(valid_o),
      .new_message_o(new_message_o), .end_message_o(end_message_o),
      .msg_count_o(msg_count_o), .overflow_o(overflow_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: committed bytes awaiting delivery, the message being written, and its raw history.
   byte unsigned exp_q[$];
   bit           last_q[$];
   byte unsigned pend_q[$];
   byte unsigned hist_q[$];
   bit m_drop = 0, m_ovf = 0, m_started = 0;
   int m_count = 0, cur_len = 0, last_len = 0, delivered = 0;

   function automatic bit has_trailer();
      for (int i = 0; i + 3 < hist_q.size(); i++)
         if (hist_q[i] == 8'h01 && hist_q[i+1] == "1" && hist_q[i+2] == "0" && hist_q[i+3] == "=")
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_write(input byte unsigned b, input bit full_now);
      bit done;
      done = (b == 8'h01) && has_trailer();
      if (m_drop) begin
         if (done) m_drop = 0;
      end else if (full_now || (done && m_count == CNT_MAX)) begin
         pend_q.delete();
         m_ovf  = 1;
         m_drop = !done;
      end else begin
         pend_q.push_back(b);
         if (done) begin
            for (int i = 0; i < pend_q.size(); i++) begin
               exp_q.push_back(pend_q[i]);
               last_q.push_back(i == pend_q.size() - 1);
            end
            pend_q.delete();
            m_count++;
         end
      end
      if (done) hist_q.delete();
      else hist_q.push_back(b);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("rst_valid", 32'(valid_o), 0);
         check("rst_ready", 32'(ready_o), 1);
         check("rst_new", 32'(new_message_o), 0);
         check("rst_end", 32'(end_message_o), 0);
         check("rst_count", 32'(msg_count_o), 0);
         check("rst_overflow", 32'(overflow_o), 0);
         check("rst_message", 32'(message_o), 0);
         exp_q.delete(); last_q.delete(); pend_q.delete(); hist_q.delete();
         m_drop = 0; m_ovf = 0; m_started = 0; m_count = 0;
      end else begin
         bit full_now;
         int pre_size;
         full_now = (exp_q.size() + pend_q.size()) == DEPTH;
         pre_size = exp_q.size();
         check("msg_count", 32'(msg_count_o), m_count);
         check("overflow", 32'(overflow_o), 32'(m_ovf));
         check("ready", 32'(ready_o), 32'(!full_now));
         if (new_message_o) begin
            check("new_msg_while_streaming", 32'(m_started), 0);
            check("new_msg_none_ready", 32'(m_count > 0), 1);
            m_started = 1;
            cur_len   = 0;
         end
         if (valid_i) model_write(data_i, full_now);
         if (valid_o) begin
            if (pre_size == 0 || !m_started) begin
               check("unexpected_byte", 32'(valid_o), 0);
            end else begin
               check("message", 32'(message_o), 32'(exp_q[0]));
               check("end_message", 32'(end_message_o), 32'(last_q[0]));
               check("valid_during_stall", 32'(stall_i), 0);
               cur_len++;
               if (last_q[0]) begin
                  m_count--;
                  m_started = 0;
                  last_len  = cur_len;
                  delivered++;
                  $display("message %0d delivered: %0d bytes", delivered, cur_len);
               end
               void'(exp_q.pop_front());
               void'(last_q.pop_front());
            end
         end else begin
            check("end_without_valid", 32'(end_message_o), 0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input byte unsigned b);
      data_i  = b;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic send_range(input string s, input int from, input int to);
      for (int i = from; i < to; i++) send_byte((s[i] == "|") ? 8'(SOH) : s[i]);
   endtask

   task automatic send_str(input string s);
      send_range(s, 0, s.len());
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_count != 0 || m_started) && n < 400) begin
         tick(1);
         n++;
      end
      check({name, "_drained"}, exp_q.size() + m_count, 0);
   endtask

   initial begin
      string msg_a, msg_b, msg_long;
      byte   held;
      msg_a = "8=FIX.4.2|35=A|10=123|";
      msg_b = "8=FIX.4.2|35=0|10=12345|";
      msg_long = "8=FIX.4.2|35=D|58=";
      for (int i = 0; i < 14; i++) msg_long = {msg_long, "x"};
      msg_long = {msg_long, "|10=000|"};

      #1 rst = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(1);

      // Single message: commit, start pulse, first byte two cycles after the count rises.
      send_str(msg_a);
      check("a_count_after_commit", 32'(msg_count_o), 1);
      check("a_no_pulse_yet", 32'(new_message_o), 0);
      tick(1);
      check("a_start_pulse", 32'(new_message_o), 1);
      tick(1);
      check("a_first_valid", 32'(valid_o), 1);
      check("a_first_byte", 32'(message_o), 'h38);
      wait_drain("a");
      check("a_length", last_len, 22);
      check("a_count_end", 32'(msg_count_o), 0);

      // Missing closing SOH holds the message.
      send_range(msg_a, 0, 21);
      tick(10);
      check("p_held_valid", 32'(valid_o), 0);
      check("p_held_count", 32'(msg_count_o), 0);
      send_byte(8'(SOH));
      wait_drain("p");
      check("p_length", last_len, 22);

      // Stall mid-stream: fourth byte 'I' held for five cycles.
      send_str(msg_a);
      tick(5);
      stall_i = 1'b1;
      #1;
      held = message_o;
      check("s_hold_byte", 32'(message_o), 'h49);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("s_stall_valid", 32'(valid_o), 0);
         check("s_stall_stable", 32'(message_o), 32'(held));
      end
      @(posedge clk);
      #1 stall_i = 1'b0;
      wait_drain("s");
      check("s_length", last_len, 22);

      // Overflow: a 40-byte message in a 32-entry FIFO is dropped whole.
      send_range(msg_long, 0, 32);
      check("o_full", 32'(ready_o), 0);
      send_range(msg_long, 32, 40);
      tick(3);
      check("o_flag", 32'(overflow_o), 1);
      check("o_count", 32'(msg_count_o), 0);
      check("o_nothing_streamed", 32'(valid_o), 0);
      check("o_ready_again", 32'(ready_o), 1);
      send_str("5=0|10=12|");
      wait_drain("o");
      check("o_next_length", last_len, 10);

      // Second message commits on the same edge the first one ends.
      send_str(msg_a);
      send_str(msg_b);
      check("c_count_steady", 32'(msg_count_o), 1);
      wait_drain("c");
      check("c_second_length", last_len, 24);

      // Asynchronous reset mid-stream, then normal operation.
      send_str(msg_a);
      tick(6);
      #1 rst = 1'b0;
      #1;
      check("r_valid", 32'(valid_o), 0);
      check("r_ready", 32'(ready_o), 1);
      check("r_count", 32'(msg_count_o), 0);
      check("r_overflow", 32'(overflow_o), 0);
      check("r_new", 32'(new_message_o), 0);
      check("r_end", 32'(end_message_o), 0);
      tick(2);
      rst = 1'b1;
      tick(1);
      send_str(msg_a);
      wait_drain("r");
      check("r_length", last_len, 22);
      check("total_messages", delivered, 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1);
   end
endmodule
